// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 datapath: reset-type encoding, pipeline
// depth limit, and helpers for lane slicing and occupancy counter sizing.
package dsp48a1_pkg;

    typedef enum logic {
        RSTTYPE_SYNC  = 1'b0,
        RSTTYPE_ASYNC = 1'b1
    } rsttype_e;

    localparam int MAX_PIPE_DEPTH = 8;

    // LSB position of a lane within a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    // Bits needed to count 0..depth set valid flags (never narrower than 1).
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dsp_pipe_cell.sv
// One pipeline stage: packed multi-lane data plus a valid bit, with
// reset > flush > enable > hold priority and optional data clearing.
module dsp_pipe_cell #(
    parameter int unsigned   DW       = 18,
    parameter bit            CLR_DATA = 1'b1,
    parameter logic [DW-1:0] RST_WORD = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cenable_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            if (CLR_DATA) data_d = RST_WORD;
        end else if (cenable_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    // Without CLR_DATA the data register is left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            if (CLR_DATA) data_q <= RST_WORD;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dsp_pipe_stage.sv
// Multi-lane, multi-stage pipeline register with stall, flush and tap output.
// Optional occupancy counter output enabled by defining DSP_PIPE_OCC_EN.
module dsp_pipe_stage
    import dsp48a1_pkg::*;
#(
    parameter int               WIDTH    = 18,
    parameter int               LANES    = 1,
    parameter int               DEPTH    = 1,
    parameter int               CLR_DATA = 1,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cenable,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH*LANES-1:0]   in_data,
    output logic                     out_valid,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic [WIDTH*LANES-1:0]   tap_data
`ifdef DSP_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    localparam int DW = WIDTH * LANES;
    localparam logic [DW-1:0] RST_WORD = {LANES{RST_VAL}};

    if (DEPTH > MAX_PIPE_DEPTH || DEPTH < 0 || WIDTH < 1 || LANES < 1) begin : g_param_check
        $error("dsp_pipe_stage: illegal DEPTH/WIDTH/LANES");
    end

    if (DEPTH == 0) begin : g_bypass
        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign tap_data  = in_data;
`ifdef DSP_PIPE_OCC_EN
        assign occupancy = '0;
`endif
    end else begin : g_pipe
        // Index 0 is the input port; index i is the output of stage i.
        logic          stage_valid [DEPTH+1];
        logic [DW-1:0] stage_data  [DEPTH+1];

        assign stage_valid[0] = in_valid;
        assign stage_data[0]  = in_data;

        for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
            dsp_pipe_cell #(
                .DW       (DW),
                .CLR_DATA (CLR_DATA != 0),
                .RST_WORD (RST_WORD)
            ) u_cell (
                .clk       (clk),
                .rst       (rst),
                .cenable_i (cenable),
                .flush_i   (flush),
                .valid_i   (stage_valid[i-1]),
                .data_i    (stage_data[i-1]),
                .valid_o   (stage_valid[i]),
                .data_o    (stage_data[i])
            );
        end

        assign out_valid = stage_valid[DEPTH];
        assign out_data  = stage_data[DEPTH];
        assign tap_data  = stage_data[DEPTH-1];

`ifdef DSP_PIPE_OCC_EN
        localparam int OCC_W = occ_width(DEPTH);
        logic [OCC_W-1:0] occ_q, occ_d, occ_shift;

        // After an enabled edge the stages hold valid[0..DEPTH-1].
        always_comb begin
            occ_shift = '0;
            for (int i = 0; i < DEPTH; i++) begin
                occ_shift = occ_shift + OCC_W'(stage_valid[i]);
            end
            occ_d = occ_q;
            if (flush) begin
                occ_d = '0;
            end else if (cenable) begin
                occ_d = occ_shift;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
`endif
    end

endmodule

// File: tb/tb_dsp_pipe_stage.sv
// Directed bench for dsp_pipe_stage: reset, latency, stall, flush, pass-through,
// and (when DSP_PIPE_OCC_EN is defined) the occupancy counter.
module tb_dsp_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cenable;
    logic        flush;
    logic        in_valid;
    logic [35:0] in_data;

    int errors = 0;
    int checks = 0;

    // dut_a: two lanes, three stages, clearing data
    logic        out_valid_a;
    logic [35:0] out_data_a, tap_data_a;
    // dut_b: one lane, three stages, data retained on reset/flush
    logic        out_valid_b;
    logic [17:0] out_data_b, tap_data_b;
    // dut_c: combinational pass-through
    logic        out_valid_c;
    logic [17:0] out_data_c, tap_data_c;
    // dut_d: four stages, used for occupancy
    logic        out_valid_d;
    logic [17:0] out_data_d, tap_data_d;
`ifdef DSP_PIPE_OCC_EN
    logic [2:0]  occ_a;
    logic [1:0]  occ_b;
    logic [0:0]  occ_c;
    logic [2:0]  occ_d;
`endif

    always #5 clk = ~clk;

    dsp_pipe_stage #(.WIDTH(18), .LANES(2), .DEPTH(3), .CLR_DATA(1), .RST_VAL(18'h0)) dut_a (
        .clk(clk), .rst(rst), .cenable(cenable), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_a), .out_data(out_data_a), .tap_data(tap_data_a)
`ifdef DSP_PIPE_OCC_EN
        , .occupancy(occ_a)
`endif
    );

    dsp_pipe_stage #(.WIDTH(18), .LANES(1), .DEPTH(3), .CLR_DATA(0), .RST_VAL(18'h0)) dut_b (
        .clk(clk), .rst(rst), .cenable(cenable), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[17:0]),
        .out_valid(out_valid_b), .out_data(out_data_b), .tap_data(tap_data_b)
`ifdef DSP_PIPE_OCC_EN
        , .occupancy(occ_b)
`endif
    );

    dsp_pipe_stage #(.WIDTH(18), .LANES(1), .DEPTH(0), .CLR_DATA(1), .RST_VAL(18'h0)) dut_c (
        .clk(clk), .rst(rst), .cenable(cenable), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[17:0]),
        .out_valid(out_valid_c), .out_data(out_data_c), .tap_data(tap_data_c)
`ifdef DSP_PIPE_OCC_EN
        , .occupancy(occ_c)
`endif
    );

    dsp_pipe_stage #(.WIDTH(18), .LANES(1), .DEPTH(4), .CLR_DATA(1), .RST_VAL(18'h0)) dut_d (
        .clk(clk), .rst(rst), .cenable(cenable), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[17:0]),
        .out_valid(out_valid_d), .out_data(out_data_d), .tap_data(tap_data_d)
`ifdef DSP_PIPE_OCC_EN
        , .occupancy(occ_d)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held two cycles with a valid all-ones input on lane 0
        rst = 1'b0; cenable = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = 36'h0_0003_FFFF;
        step();
        chk("rst1_valid", 36'(out_valid_a), 36'h0);
        chk("rst1_data",  out_data_a, 36'h0);
        step();
        chk("rst2_valid", 36'(out_valid_a), 36'h0);
        chk("rst2_data",  out_data_a, 36'h0);

        rst = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        step();
        chk("rel_valid", 36'(out_valid_a), 36'h0);
        chk("rel_data",  out_data_a, 36'h0);
        step();
        step();

        // Latency: two back-to-back samples through three stages
        in_valid = 1'b1; in_data = {18'h00001, 18'h00002};
        step();
        in_data = {18'h00003, 18'h00004};
        step();
        chk("lat_tap_a",   tap_data_a, {18'h00001, 18'h00002});
        chk("lat_e2_vld",  36'(out_valid_a), 36'h0);
        in_valid = 1'b0; in_data = '0;
        step();
        chk("lat_e3_vld",  36'(out_valid_a), 36'h1);
        chk("lat_e3_data", out_data_a, {18'h00001, 18'h00002});
        chk("lat_e3_tap",  tap_data_a, {18'h00003, 18'h00004});
        chk("lat_b_data",  36'(out_data_b), 36'h00002);
        step();
        chk("lat_e4_vld",  36'(out_valid_a), 36'h1);
        chk("lat_e4_data", out_data_a, {18'h00003, 18'h00004});
        chk("lat_e4_tap",  tap_data_a, 36'h0);
        step();
        chk("lat_e5_vld",  36'(out_valid_a), 36'h0);

        // Stall: one sample in, five frozen cycles, two more enabled edges
        in_valid = 1'b1; in_data = 36'h15;
        step();
        cenable = 1'b0; in_data = 36'h0_0003_FFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_vld", 36'(out_valid_a), 36'h0);
            chk("stall_tap", tap_data_a, 36'h0);
        end
        cenable = 1'b1; in_valid = 1'b0; in_data = '0;
        step();
        chk("stall_tap_out", tap_data_a, 36'h15);
        chk("stall_vld_pre", 36'(out_valid_a), 36'h0);
        step();
        chk("stall_exit_vld",  36'(out_valid_a), 36'h1);
        chk("stall_exit_data", out_data_a, 36'h15);

        // Flush with three valid samples in flight
        in_valid = 1'b1; in_data = {18'h00011, 18'h00012};
        step();
        in_data = {18'h00013, 18'h00014};
        step();
        in_data = {18'h00015, 18'h00016};
        step();
        chk("fl_pre_vld",  36'(out_valid_a), 36'h1);
        chk("fl_pre_data", out_data_a, {18'h00011, 18'h00012});
        flush = 1'b1; in_data = {18'h00017, 18'h00018};
        step();
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
        chk("fl_vld_a",  36'(out_valid_a), 36'h0);
        chk("fl_data_a", out_data_a, 36'h0);
        chk("fl_tap_a",  tap_data_a, 36'h0);
        chk("fl_vld_b",  36'(out_valid_b), 36'h0);
        chk("fl_data_b", 36'(out_data_b), 36'h00012);
        chk("fl_tap_b",  36'(tap_data_b), 36'h00014);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_drain_a", 36'(out_valid_a), 36'h0);
            chk("fl_drain_b", 36'(out_valid_b), 36'h0);
        end

        // Pass-through ignores reset, stall and flush
        rst = 1'b0; cenable = 1'b0; flush = 1'b1;
        in_valid = 1'b1; in_data = 36'h2AAAA;
        #1;
        chk("pt_data", 36'(out_data_c), 36'h2AAAA);
        chk("pt_vld",  36'(out_valid_c), 36'h1);
        chk("pt_tap",  36'(tap_data_c), 36'h2AAAA);
        in_valid = 1'b0; in_data = 36'h15555;
        #1;
        chk("pt_data2", 36'(out_data_c), 36'h15555);
        chk("pt_vld2",  36'(out_valid_c), 36'h0);
        step();
        flush = 1'b0; cenable = 1'b1;

        // Occupancy sequence: valid, bubble, valid, valid, then flush
        rst = 1'b1; in_valid = 1'b1; in_data = 36'h7;
        step();
`ifdef DSP_PIPE_OCC_EN
        chk("occ_1", 36'(occ_d), 36'h1);
`endif
        in_valid = 1'b0; in_data = '0;
        step();
`ifdef DSP_PIPE_OCC_EN
        chk("occ_2", 36'(occ_d), 36'h1);
`endif
        in_valid = 1'b1; in_data = 36'h8;
        step();
`ifdef DSP_PIPE_OCC_EN
        chk("occ_3", 36'(occ_d), 36'h2);
`endif
        chk("seq_a_vld",  36'(out_valid_a), 36'h1);
        chk("seq_a_data", out_data_a, 36'h7);
        in_data = 36'h9;
        step();
`ifdef DSP_PIPE_OCC_EN
        chk("occ_4", 36'(occ_d), 36'h3);
`endif
        chk("seq_a_bub",  36'(out_valid_a), 36'h0);
        chk("seq_d_tap",  36'(tap_data_d), 36'h0);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef DSP_PIPE_OCC_EN
        chk("occ_flush", 36'(occ_d), 36'h0);
`endif
        chk("seq_d_flush", 36'(out_valid_d), 36'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
